// File: rtl/dlx_mult_seq.sv
// dlx_mult_seq: multi-cycle 32x32 shift-add multiplier for the DLX EX stage.
// Has no adder of its own. It drives the operand pins of a 32-bit adder in the
// parent and uses that adder's sum and carry-out in the same cycle.
// Signed operands are converted to magnitudes first (ABS_A/ABS_B). The
// 64-bit result is negated afterwards (FIX_LO/FIX_HI) when the signs differ.
// Optional feature: define MULT_OVF_EN to generate the ovf flag. The flag is
// set when the 64-bit product does not fit in prod_lo. Without the macro, ovf
// is tied low.
module dlx_mult_seq #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic        kill,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_sum,
   input  logic        add_cout,
   output logic        busy,
   output logic        done,
   output logic [31:0] prod_hi,
   output logic [31:0] prod_lo,
   output logic        ovf
);

   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ABS_A, S_ABS_B, S_MUL, S_FIX_LO, S_FIX_HI, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      mcand_q, mcand_d;
   logic [31:0]      phi_q, phi_d;
   logic [31:0]      plo_q, plo_d;
   logic [31:0]      prod_hi_q, prod_hi_d;
   logic [31:0]      prod_lo_q, prod_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sgn_q, sgn_d;
   logic             neg_a_q, neg_a_d;
   logic             neg_b_q, neg_b_d;
   logic             cy_q, cy_d;
   logic             neg_res;
`ifdef MULT_OVF_EN
   logic             ovf_q, ovf_d;
   logic             ovf_res;
`endif

   // The final result is negative when exactly one operand was negative.
   assign neg_res = neg_a_q ^ neg_b_q;

   // Next-state, datapath updates and adder operand selection.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      phi_d     = phi_q;
      plo_d     = plo_q;
      prod_hi_d = prod_hi_q;
      prod_lo_d = prod_lo_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      cy_d      = cy_q;
`ifdef MULT_OVF_EN
      ovf_d     = ovf_q;
`endif
      add_a     = 32'd0;
      add_b     = 32'd0;

      case (state_q)
         S_IDLE: begin
            // kill has priority over start
            if (start && !kill) begin
               sgn_d   = is_signed;
               mcand_d = op_a;
               plo_d   = op_b;
               phi_d   = 32'd0;
               cnt_d   = '0;
               neg_a_d = is_signed & op_a[31];
               neg_b_d = is_signed & op_b[31];
`ifdef MULT_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = is_signed ? S_ABS_A : S_MUL;
            end
         end
         S_ABS_A: begin
            // Two's-complement negate as ~x + 1. 0x80000000 maps to itself,
            // which reads correctly as the unsigned magnitude 2^31.
            add_a   = neg_a_q ? ~mcand_q : mcand_q;
            add_b   = {31'd0, neg_a_q};
            mcand_d = add_sum;
            state_d = S_ABS_B;
         end
         S_ABS_B: begin
            add_a   = neg_b_q ? ~plo_q : plo_q;
            add_b   = {31'd0, neg_b_q};
            plo_d   = add_sum;
            phi_d   = 32'd0;
            cnt_d   = '0;
            state_d = S_MUL;
         end
         S_MUL: begin
            // One shift-add step. The adder carry becomes the new top bit of phi.
            add_a = phi_q;
            add_b = plo_q[0] ? mcand_q : 32'd0;
            {phi_d, plo_d} = {plo_q[0] & add_cout, add_sum, plo_q[31:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = sgn_q ? S_FIX_LO : S_DONE;
            end
         end
         S_FIX_LO: begin
            add_a   = neg_res ? ~plo_q : plo_q;
            add_b   = {31'd0, neg_res};
            plo_d   = add_sum;
            cy_d    = add_cout & neg_res;
            state_d = S_FIX_HI;
         end
         S_FIX_HI: begin
            add_a   = neg_res ? ~phi_q : phi_q;
            add_b   = {31'd0, cy_q};
            phi_d   = add_sum;
            state_d = S_DONE;
         end
         S_DONE: begin
            prod_hi_d = phi_q;
            prod_lo_d = plo_q;
`ifdef MULT_OVF_EN
            ovf_d     = ovf_res;
`endif
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A flush abandons the operation and leaves the last result in place.
      if (kill && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         prod_hi_d = prod_hi_q;
         prod_lo_d = prod_lo_q;
`ifdef MULT_OVF_EN
         ovf_d     = ovf_q;
`endif
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= 32'd0;
         phi_q     <= 32'd0;
         plo_q     <= 32'd0;
         prod_hi_q <= 32'd0;
         prod_lo_q <= 32'd0;
         cnt_q     <= '0;
         sgn_q     <= 1'b0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         cy_q      <= 1'b0;
`ifdef MULT_OVF_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         phi_q     <= phi_d;
         plo_q     <= plo_d;
         prod_hi_q <= prod_hi_d;
         prod_lo_q <= prod_lo_d;
         cnt_q     <= cnt_d;
         sgn_q     <= sgn_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         cy_q      <= cy_d;
`ifdef MULT_OVF_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE) && !kill;

   // The product is shown in the done cycle itself, then held from the registers.
   assign prod_hi = done ? phi_q : prod_hi_q;
   assign prod_lo = done ? plo_q : prod_lo_q;

`ifdef MULT_OVF_EN
   assign ovf_res = sgn_q ? (phi_q != {32{plo_q[31]}}) : (phi_q != 32'd0);
   assign ovf     = done ? ovf_res : ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dlx_mult_seq.sv
// tb_dlx_mult_seq: self-checking bench for dlx_mult_seq, including a model of the
// parent's 32-bit adder. Expected products come from 64-bit arithmetic and go
// into a queue when an operation is issued. Each is popped when done is seen.
module tb_dlx_mult_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic        kill;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_sum;
   logic        add_cout;
   logic        busy;
   logic        done;
   logic [31:0] prod_hi;
   logic [31:0] prod_lo;
   logic        ovf;
   logic [32:0] add_full;

   int          n_pass;
   int          n_total;
   logic [64:0] exp_q[$];
   logic [64:0] last_exp;

   dlx_mult_seq dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .kill(kill),
      .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_cout(add_cout), .busy(busy), .done(done),
      .prod_hi(prod_hi), .prod_lo(prod_lo), .ovf(ovf)
   );

   // Adder instance that the parent would provide
   assign add_full = {1'b0, add_a} + {1'b0, add_b};
   assign add_sum  = add_full[31:0];
   assign add_cout = add_full[32];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   // Drive a start for one cycle (cycle 0); optionally queue the expected result.
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input bit push);
      logic [63:0] ea, eb, p;
      logic        eo;
      ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
`ifdef MULT_OVF_EN
      eo = sgn ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'd0);
`else
      eo = 1'b0;
`endif
      if (push) exp_q.push_back({eo, p});
      op_a = a; op_b = b; is_signed = sgn; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called in cycle 1. Returns the cycle index of done (60 = never seen) and
   // the number of cycles before it in which busy was low.
   task automatic wait_done(output int lat, output int busy_low);
      lat = 1; busy_low = 0;
      while (done !== 1'b1 && lat < 60) begin
         if (busy !== 1'b1) busy_low++;
         tick();
         lat++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; kill = 1'b0; is_signed = 1'b0;
      op_a = 32'd0; op_b = 32'd0;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      n_total++; if (prod_hi !== 32'd0) $display("FAIL reset_prod_hi: got %h want 0", prod_hi); else n_pass++;
      n_total++; if (prod_lo !== 32'd0) $display("FAIL reset_prod_lo: got %h want 0", prod_lo); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
      n_total++; if ({add_a, add_b} !== 64'd0) $display("FAIL reset_adder_ops: got %h/%h want 0/0", add_a, add_b); else n_pass++;
      last_exp = '0;
   endtask

   task automatic test_multiply();
      logic [31:0] ta [8];
      logic [31:0] tb [8];
      logic        ts [8];
      ta = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000};
      tb = '{32'd6, 32'hFFFFFFFF, 32'd5,        32'h80000000, 32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'd1};
      ts = '{1'b0,  1'b0,         1'b1,         1'b1,         1'b1,  1'b1,         1'b1,         1'b0};
      for (int i = 0; i < 16; i++) begin
         logic [31:0] a, b;
         logic        s;
         int          lat, bl, want_lat;
         logic [64:0] e;
         if (i < 8) begin
            a = ta[i]; b = tb[i]; s = ts[i];
         end else begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i % 3 == 0) b = 32'($urandom_range(0, 255));
         end
         want_lat = s ? 37 : 33;
         issue(a, b, s, 1'b1);
         wait_done(lat, bl);
         n_total++; if (lat != want_lat) $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, want_lat); else n_pass++;
         n_total++; if (bl != 0) $display("FAIL mul%0d_busy: got %0d idle cycles want 0", i, bl); else n_pass++;
         n_total++; if (busy !== 1'b1) $display("FAIL mul%0d_busy_done: got %b want 1", i, busy); else n_pass++;
         n_total++; if ({add_a, add_b} !== 64'd0) $display("FAIL mul%0d_adder_done: got %h/%h want 0/0", i, add_a, add_b); else n_pass++;
         e = '0;
         n_total++;
         if (exp_q.size() == 0) $display("FAIL mul%0d_queue: got empty want entry", i);
         else begin n_pass++; e = exp_q.pop_front(); end
         last_exp = e;
         n_total++; if (prod_hi !== e[63:32]) $display("FAIL mul%0d_prod_hi: got %h want %h", i, prod_hi, e[63:32]); else n_pass++;
         n_total++; if (prod_lo !== e[31:0]) $display("FAIL mul%0d_prod_lo: got %h want %h", i, prod_lo, e[31:0]); else n_pass++;
         n_total++; if (ovf !== e[64]) $display("FAIL mul%0d_ovf: got %b want %b", i, ovf, e[64]); else n_pass++;
         tick();
         n_total++; if ({busy, done} !== 2'b00) $display("FAIL mul%0d_after: got busy/done %b want 00", i, {busy, done}); else n_pass++;
         n_total++; if ({prod_hi, prod_lo} !== e[63:0]) $display("FAIL mul%0d_hold: got %h want %h", i, {prod_hi, prod_lo}, e[63:0]); else n_pass++;
      end
   endtask

   task automatic test_kill();
      logic [64:0] prev;
      logic [64:0] e;
      int          seen, lat, bl;
      prev = last_exp;
      seen = 0;
      issue(32'd2, 32'd3, 1'b1, 1'b0);
      for (int c = 1; c < 20; c++) begin
         start = (c == 10);
         if (c == 10) begin op_a = 32'd9; op_b = 32'd9; is_signed = 1'b0; end
         if (done === 1'b1) seen++;
         tick();
      end
      start = 1'b0;
      // cycle 20
      kill = 1'b1;
      #1;
      n_total++; if (done !== 1'b0) $display("FAIL kill_done_c20: got %b want 0", done); else n_pass++;
      tick();
      kill = 1'b0;
      // cycle 21
      n_total++; if (busy !== 1'b0) $display("FAIL kill_busy_c21: got %b want 0", busy); else n_pass++;
      n_total++; if (seen != 0) $display("FAIL kill_no_done: got %0d pulses want 0", seen); else n_pass++;
      n_total++; if ({ovf, prod_hi, prod_lo} !== prev) $display("FAIL kill_prod_kept: got %h want %h", {ovf, prod_hi, prod_lo}, prev); else n_pass++;
      issue(32'd9, 32'd9, 1'b0, 1'b1);
      wait_done(lat, bl);
      n_total++; if (lat != 33) $display("FAIL kill_restart_latency: got %0d want 33", lat); else n_pass++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
      last_exp = e;
      n_total++; if ({prod_hi, prod_lo} !== e[63:0]) $display("FAIL kill_restart_prod: got %h want %h", {prod_hi, prod_lo}, e[63:0]); else n_pass++;
      tick();
      // kill during DONE
      issue(32'd5, 32'd5, 1'b0, 1'b0);
      for (int c = 1; c < 33; c++) tick();
      n_total++; if (done !== 1'b1) $display("FAIL kill_in_done_pre: got %b want 1", done); else n_pass++;
      kill = 1'b1;
      #1;
      n_total++; if (done !== 1'b0) $display("FAIL kill_in_done_forced: got %b want 0", done); else n_pass++;
      tick();
      kill = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL kill_in_done_busy: got %b want 0", busy); else n_pass++;
      n_total++; if ({prod_hi, prod_lo} !== last_exp[63:0]) $display("FAIL kill_in_done_prod: got %h want %h", {prod_hi, prod_lo}, last_exp[63:0]); else n_pass++;
      // kill beats start in IDLE
      op_a = 32'd4; op_b = 32'd4; is_signed = 1'b0; start = 1'b1; kill = 1'b1;
      tick();
      start = 1'b0; kill = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL kill_over_start: got busy %b want 0", busy); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [64:0] e;
      logic [63:0] pb;
      int          lat, bl;
      issue(32'd1000, 32'd3000, 1'b0, 1'b1);
      wait_done(lat, bl);
      // start held high from the DONE cycle onward
      op_a = 32'd11; op_b = 32'd13; is_signed = 1'b0; start = 1'b1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
      n_total++; if ({prod_hi, prod_lo} !== e[63:0]) $display("FAIL b2b_first_prod: got %h want %h", {prod_hi, prod_lo}, e[63:0]); else n_pass++;
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_start_in_done_ignored: got busy %b want 0", busy); else n_pass++;
      pb = 64'd143;
      exp_q.push_back({1'b0, pb});
      tick();
      start = 1'b0;
      n_total++; if (busy !== 1'b1) $display("FAIL b2b_next_accepted: got busy %b want 1", busy); else n_pass++;
      wait_done(lat, bl);
      n_total++; if (lat != 33) $display("FAIL b2b_latency: got %0d want 33", lat); else n_pass++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
      last_exp = e;
      n_total++; if ({ovf, prod_hi, prod_lo} !== e) $display("FAIL b2b_second_prod: got %h want %h", {ovf, prod_hi, prod_lo}, e); else n_pass++;
      tick();
   endtask

   task automatic test_rst_mid();
      int seen;
      logic [64:0] e;
      int lat, bl;
      seen = 0;
      issue(32'hFFFFFFF9, 32'd9, 1'b1, 1'b0);
      for (int c = 1; c < 15; c++) tick();
      // cycle 15
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_busy_done: got %b want 00", {busy, done}); else n_pass++;
      n_total++; if ({prod_hi, prod_lo} !== 64'd0) $display("FAIL rst_mid_prod: got %h want 0", {prod_hi, prod_lo}); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL rst_mid_ovf: got %b want 0", ovf); else n_pass++;
      n_total++; if ({add_a, add_b} !== 64'd0) $display("FAIL rst_mid_adder: got %h/%h want 0/0", add_a, add_b); else n_pass++;
      for (int c = 0; c < 30; c++) begin
         if (done === 1'b1) seen++;
         tick();
      end
      n_total++; if (seen != 0) $display("FAIL rst_mid_no_done: got %0d pulses want 0", seen); else n_pass++;
      issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);
      wait_done(lat, bl);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
      n_total++; if ({ovf, prod_hi, prod_lo} !== e) $display("FAIL rst_mid_recover: got %h want %h", {ovf, prod_hi, prod_lo}, e); else n_pass++;
      tick();
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_multiply();
      test_kill();
      test_back_to_back();
      test_rst_mid();
      n_total++; if (exp_q.size() != 0) $display("FAIL queue_drained: got %0d entries want 0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
